// File: rtl/entity_pixel_renderer_pkg.sv
// Shared constants, entity-code layout and orientation encodings for the
// entity pixel renderer and its sprite ROM.
package entity_pixel_renderer_pkg;

  localparam int unsigned UPSCALE_FACTOR = 5;
  localparam int unsigned TILE_SIZE      = 8;
  localparam int unsigned TILE_LEN_PIXEL = UPSCALE_FACTOR * TILE_SIZE;
  localparam int unsigned SCREEN_SIZE_H  = 640;
  localparam int unsigned SCREEN_SIZE_V  = 480;

  localparam int unsigned COUNTER_W  = 10;
  localparam int unsigned ENTITY_W   = 9;
  localparam int unsigned ID_W       = 4;
  localparam int unsigned ROW_W      = 3;
  localparam int unsigned ORIENT_W   = 2;
  localparam int unsigned UP_W       = 3;
  localparam int unsigned COL_W      = 3;
  localparam int unsigned ROM_ADDR_W = ID_W + ROW_W;
  localparam int unsigned ROM_DATA_W = TILE_SIZE;
  localparam int unsigned TILE_BITS  = TILE_SIZE * TILE_SIZE;

  localparam logic [ENTITY_W-1:0] ENTITY_NONE = 9'h1FF;
  localparam logic [ID_W-1:0]     ID_EMPTY    = 4'hF;

  typedef enum logic [ORIENT_W-1:0] {
    ORIENT_NORM         = 2'b00,
    ORIENT_MIRROR       = 2'b01,
    ORIENT_TRANS        = 2'b10,
    ORIENT_TRANS_MIRROR = 2'b11
  } orient_e;

  // Entity code as delivered by the detection-combination unit (MSB first).
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [ID_W-1:0]  id;
    orient_e          orient;
  } entity_t;

endpackage

// File: rtl/entity_pixel_renderer_sprite_rom.sv
// Sprite art: 16 sprites of 8x8 pixels, one 8-bit row per lookup.
// Ports:
//   addr       in  {id, row} of the requested sprite row
//   row_bits_c out 8-bit row, column 0 in bit 7 (combinational)
module sprite_rom
  import entity_pixel_renderer_pkg::*;
(
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [ROM_DATA_W-1:0] row_bits_c
);

  logic [ID_W-1:0]      id;
  logic [ROW_W-1:0]     rr;
  logic [TILE_BITS-1:0] tile;

  assign id = addr[ROM_ADDR_W-1 -: ID_W];
  assign rr = addr[ROW_W-1:0];

  // Each tile holds row 0 in its top byte; ID F is the empty sprite.
  always_comb begin
    tile = '0;
    case (id)
      4'h0:    tile = 64'h3C42_8181_8181_423C;
      4'h1:    tile = 64'h8142_2418_1824_4281;
      4'h2:    tile = 64'hFF81_8181_8181_81FF;
      4'h3:    tile = 64'h1818_18FF_FF18_1818;
      4'h4:    tile = 64'h0102_0408_1020_4080;
      4'h5:    tile = 64'hAA55_AA55_AA55_AA55;
      4'h6:    tile = 64'hF0F0_F0F0_0F0F_0F0F;
      4'h7:    tile = 64'h0018_3C7E_FFFF_6600;
      4'h8:    tile = 64'h7E81_A581_A599_817E;
      4'h9:    tile = 64'hC3C3_0000_0000_C3C3;
      4'hA:    tile = 64'h1038_7CFE_7C38_1000;
      4'hB:    tile = 64'hFFFF_0000_FFFF_0000;
      4'hC:    tile = 64'h8040_2010_0804_0201;
      4'hD:    tile = 64'h3C3C_3C3C_3C3C_3C3C;
      4'hE:    tile = 64'h0F1F_3F7F_FEFC_F8F0;
      default: tile = '0;
    endcase
    // Row r sits at bits [8*(7-r) +: 8]; ~rr is 7-r.
    row_bits_c = tile[{~rr, 3'b000} +: ROM_DATA_W];
  end

endmodule

// File: rtl/entity_pixel_renderer.sv
// Turns the per-pixel entity code into a sprite pixel: tracks the sub-tile
// column from counter_H, applies entity orientation and reads the sprite ROM.
// Two-cycle latency from counter_H/in_entity to the outputs.
// Ports:
//   clk, reset   pixel clock, asynchronous active-high reset
//   counter_H/V  scan position (H advances by one per clock)
//   in_entity    {row, id, orient}; ID F means no entity
//   pixel_on     sprite pixel set (registered)
//   pixel_id     entity ID for palette selection (registered)
//   pixel_valid  output corresponds to an active-area pixel (registered)
module entity_pixel_renderer #(
  parameter int unsigned UPSCALE_FACTOR = entity_pixel_renderer_pkg::UPSCALE_FACTOR,
  parameter int unsigned TILE_SIZE      = entity_pixel_renderer_pkg::TILE_SIZE,
  parameter int unsigned H_ACTIVE       = entity_pixel_renderer_pkg::SCREEN_SIZE_H,
  parameter int unsigned V_ACTIVE       = entity_pixel_renderer_pkg::SCREEN_SIZE_V
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_H,
  input  logic [9:0] counter_V,
  input  logic [8:0] in_entity,
  output logic       pixel_on,
  output logic [3:0] pixel_id,
  output logic       pixel_valid
);

  import entity_pixel_renderer_pkg::*;

  entity_t ent;
  assign ent = entity_t'(in_entity);

  // Stage 0: sub-tile column tracker. up_next/col_next describe the pixel
  // currently on counter_H; the registers hold the previous pixel's values.
  logic [UP_W-1:0]  up_cnt, up_next;
  logic [COL_W-1:0] col_cnt, col_next;

  always_comb begin
    up_next  = UP_W'(up_cnt + 1'b1);
    col_next = col_cnt;
    if (counter_H == '0) begin
      up_next  = '0;
      col_next = '0;
    end else if (up_cnt == UP_W'(UPSCALE_FACTOR - 1)) begin
      up_next  = '0;
      col_next = (col_cnt == COL_W'(TILE_SIZE - 1)) ? '0 : COL_W'(col_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_cnt  <= '0;
      col_cnt <= '0;
    end else begin
      up_cnt  <= up_next;
      col_cnt <= col_next;
    end
  end

  // Stage 1: capture entity fields, column and active-area flag.
  logic [ROW_W-1:0] s1_row;
  logic [ID_W-1:0]  s1_id;
  orient_e          s1_orient;
  logic [COL_W-1:0] s1_col;
  logic             s1_active;
  logic             s1_blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_row    <= '0;
      s1_id     <= '0;
      s1_orient <= ORIENT_NORM;
      s1_col    <= '0;
      s1_active <= 1'b0;
      s1_blank  <= 1'b1;
    end else begin
      s1_row    <= ent.row;
      s1_id     <= ent.id;
      s1_orient <= ent.orient;
      s1_col    <= col_next;
      s1_active <= (counter_H < COUNTER_W'(H_ACTIVE)) && (counter_V < COUNTER_W'(V_ACTIVE));
      s1_blank  <= (ent.id == ID_EMPTY);
    end
  end

  // Orientation map from screen (row, col) to ROM (rr, cc); ~x is 7-x.
  logic [ROW_W-1:0] rom_rr;
  logic [COL_W-1:0] rom_cc;

  always_comb begin
    rom_rr = s1_row;
    rom_cc = s1_col;
    case (s1_orient)
      ORIENT_NORM:         begin rom_rr = s1_row;  rom_cc = s1_col;  end
      ORIENT_MIRROR:       begin rom_rr = s1_row;  rom_cc = ~s1_col; end
      ORIENT_TRANS:        begin rom_rr = s1_col;  rom_cc = s1_row;  end
      ORIENT_TRANS_MIRROR: begin rom_rr = ~s1_col; rom_cc = s1_row;  end
      default:             begin rom_rr = s1_row;  rom_cc = s1_col;  end
    endcase
  end

  logic [ROM_DATA_W-1:0] rom_row;
  logic                  rom_bit;

  sprite_rom u_sprite_rom (
    .addr       ({s1_id, rom_rr}),
    .row_bits_c (rom_row)
  );

  // Column 0 is the MSB of the row.
  assign rom_bit = rom_row[~rom_cc];

  // Stage 2: registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_on    <= 1'b0;
      pixel_id    <= ID_EMPTY;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= s1_active & ~s1_blank & rom_bit;
      pixel_id    <= s1_blank ? ID_EMPTY : s1_id;
      pixel_valid <= s1_active;
    end
  end

endmodule

// File: tb/tb_entity_pixel_renderer.sv
// Scoreboard bench for entity_pixel_renderer: the stimulus process pushes the
// expected output of every driven pixel; a monitor pops and compares it when
// that pixel reaches the outputs two clocks later.
module tb_entity_pixel_renderer;
  import entity_pixel_renderer_pkg::*;

  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;

  // Reference sprite art, row 0 in the top byte, column 0 as MSB of a row.
  localparam logic [63:0] ART [16] = '{
    64'h3C42_8181_8181_423C, 64'h8142_2418_1824_4281,
    64'hFF81_8181_8181_81FF, 64'h1818_18FF_FF18_1818,
    64'h0102_0408_1020_4080, 64'hAA55_AA55_AA55_AA55,
    64'hF0F0_F0F0_0F0F_0F0F, 64'h0018_3C7E_FFFF_6600,
    64'h7E81_A581_A599_817E, 64'hC3C3_0000_0000_C3C3,
    64'h1038_7CFE_7C38_1000, 64'hFFFF_0000_FFFF_0000,
    64'h8040_2010_0804_0201, 64'h3C3C_3C3C_3C3C_3C3C,
    64'h0F1F_3F7F_FEFC_F8F0, 64'h0000_0000_0000_0000
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] counter_H = '0;
  logic [9:0] counter_V = '0;
  logic [8:0] in_entity = ENTITY_NONE;
  logic       pixel_on;
  logic [3:0] pixel_id;
  logic       pixel_valid;

  entity_pixel_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .counter_H   (counter_H),
    .counter_V   (counter_V),
    .in_entity   (in_entity),
    .pixel_on    (pixel_on),
    .pixel_id    (pixel_id),
    .pixel_valid (pixel_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         h;
    logic       on;
    logic [3:0] id;
    logic       valid;
    bit         chk_on;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   synced = 1'b0;

  task automatic check(input string name, input int h, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at h=%0d: got %0h, expected %0h", name, h, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input int h);
    check("rst_pixel_on", h, 4'(pixel_on), 4'h0);
    check("rst_pixel_id", h, pixel_id, 4'hF);
    check("rst_pixel_valid", h, 4'(pixel_valid), 4'h0);
  endtask

  // Reference: column = (h mod 40) / 5, orientation applied, MSB-first ROM bit.
  function automatic exp_t model(input int h, input int v, input logic [8:0] ent,
                                 input bit sync);
    exp_t e;
    int r  = int'(ent[8:6]);
    int id = int'(ent[5:2]);
    int o  = int'(ent[1:0]);
    int c  = (h % int'(TILE_LEN_PIXEL)) / int'(UPSCALE_FACTOR);
    int rr = r;
    int cc = c;
    bit act   = (h < int'(SCREEN_SIZE_H)) && (v < int'(SCREEN_SIZE_V));
    bit blank = (id == 15);
    logic [63:0] tile;
    case (o)
      0: begin rr = r;     cc = c;     end
      1: begin rr = r;     cc = 7 - c; end
      2: begin rr = c;     cc = r;     end
      default: begin rr = 7 - c; cc = r; end
    endcase
    tile     = ART[id];
    e.due    = 0;
    e.h      = h;
    e.valid  = act;
    e.id     = blank ? 4'hF : 4'(id);
    e.on     = act && !blank && tile[63 - 8 * rr - cc];
    e.chk_on = sync || blank;
    return e;
  endfunction

  function automatic logic [8:0] random_entity();
    int sel = $urandom_range(0, 9);
    logic [3:0] id;
    if (sel == 0) return ENTITY_NONE;
    id = (sel == 1) ? 4'hF : 4'($urandom_range(0, 14));
    return {3'($urandom_range(0, 7)), id, 2'($urandom_range(0, 3))};
  endfunction

  // Drives one pixel (caller aligns to negedge) and optionally queues its result.
  task automatic put_pixel(input int h, input int v, input logic [8:0] ent,
                           input bit push);
    exp_t e;
    counter_H = 10'(h);
    counter_V = 10'(v);
    in_entity = ent;
    if (h == 0) synced = 1'b1;
    if (push) begin
      e = model(h, v, ent, synced);
      e.due = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_line(input int v, input bit rand_ent, input logic [8:0] ent);
    for (int h = 0; h < int'(H_TOTAL); h++) begin
      @(negedge clk);
      put_pixel(h, v, rand_ent ? random_entity() : ent, 1'b1);
    end
  endtask

  // Monitor: compares each queued pixel when it reaches the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        if (e.due != cyc) begin
          checks++;
          errors++;
          $display("FAIL sched at h=%0d: due %0d, now %0d", e.h, e.due, cyc);
        end else begin
          check("pixel_valid", e.h, 4'(pixel_valid), 4'(e.valid));
          check("pixel_id", e.h, pixel_id, e.id);
          if (e.chk_on) check("pixel_on", e.h, 4'(pixel_on), 4'(e.on));
        end
      end
    end
  end

  initial begin
    // Power-up reset: outputs clear asynchronously and hold until release.
    #1 reset = 1'b1;
    #1 check_reset_outputs(-1);
    repeat (3) begin
      @(negedge clk);
      #1 check_reset_outputs(-1);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed lines.
    run_line(10, 1'b0, {3'd0, 4'd1, 2'b00});
    run_line(10, 1'b0, {3'd0, 4'd1, 2'b01});
    run_line(10, 1'b0, {3'd2, 4'd1, 2'b10});
    run_line(10, 1'b0, {3'd5, 4'd8, 2'b11});
    run_line(10, 1'b0, ENTITY_NONE);
    run_line(10, 1'b0, {3'd3, 4'hF, 2'b10});
    run_line(479, 1'b1, '0);
    run_line(480, 1'b1, '0);

    // Randomized lines.
    for (int n = 0; n < 4; n++) run_line($urandom_range(0, V_TOTAL - 1), 1'b1, '0);

    // Mid-line reset with a valid entity present.
    for (int h = 0; h < 123; h++) begin
      @(negedge clk);
      put_pixel(h, 20, {3'd1, 4'd1, 2'b00}, 1'b1);
    end
    @(negedge clk);
    reset  = 1'b1;
    synced = 1'b0;
    exp_q.delete();
    put_pixel(123, 20, {3'd1, 4'd1, 2'b00}, 1'b0);
    #1 check_reset_outputs(123);
    for (int h = 124; h < 127; h++) begin
      @(negedge clk);
      put_pixel(h, 20, {3'd1, 4'd1, 2'b00}, 1'b0);
      #1 check_reset_outputs(h);
    end
    @(negedge clk);
    reset = 1'b0;
    put_pixel(127, 20, {3'd1, 4'd1, 2'b00}, 1'b1);
    for (int h = 128; h < int'(H_TOTAL); h++) begin
      @(negedge clk);
      put_pixel(h, 20, (h < 200) ? {3'd1, 4'd1, 2'b00} : random_entity(), 1'b1);
    end
    run_line(21, 1'b1, '0);
    run_line(22, 1'b0, {3'd6, 4'd3, 2'b01});

    // Drain the pipeline; anything still queued never reached the outputs.
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pixels pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
